// File: rtl/rom_line_fetcher.sv
// Refills one instruction-cache line from a word-wide backing ROM over a req/ack handshake.
// Optional ack watchdog enabled by defining ROM_FETCH_TIMEOUT_EN.
module rom_line_fetcher #(
   parameter int unsigned WORD_ADR_SIZE  = 3,
   parameter logic [31:0] ROM_BASE       = 32'h8000_0000,
   parameter int unsigned ROM_WORDS      = 16384,
   parameter int unsigned MEM_AW         = 14,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rom_re,
   input  logic [31:0]       rom_addr,
   output logic [31:0]       rom_out [0:(1<<WORD_ADR_SIZE)-1],
   output logic              rom_oe,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              fetch_err
);

   localparam int unsigned          LINE_WORDS = 1 << WORD_ADR_SIZE;
   localparam logic [31:0]          NOP_WORD   = 32'h0000_0013;
   localparam logic [32:0]          ROM_LO     = {1'b0, ROM_BASE};
   localparam logic [32:0]          ROM_HI     = ROM_LO + 33'(4 * ROM_WORDS);
   localparam logic [WORD_ADR_SIZE-1:0] LAST_CNT = WORD_ADR_SIZE'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DONE,
      S_COOL
   } state_t;

   state_t                   state_q, state_d;
   logic [WORD_ADR_SIZE-1:0] cnt_q, cnt_d;
   logic [WORD_ADR_SIZE-1:0] cnt_nxt;
   logic                     mem_req_q, mem_req_d;
   logic [MEM_AW-1:0]        mem_addr_q, mem_addr_d;
   logic [31:0]              rom_out_q [0:LINE_WORDS-1];

   logic                     wr_en;
   logic [31:0]              wr_data;
   logic                     fill_nop;
   logic                     advance;

   logic [31:0]              line_base;
   logic [31:0]              line_offset;
   logic                     in_range;
   logic [MEM_AW-1:0]        line_idx;
   logic                     unused_bits;

   // Line base and its word index inside the backing ROM.
   assign line_base   = {rom_addr[31:WORD_ADR_SIZE+2], {(WORD_ADR_SIZE+2){1'b0}}};
   assign line_offset = line_base - ROM_BASE;
   assign line_idx    = line_offset[MEM_AW+1:2];
   assign in_range    = ({1'b0, line_base} >= ROM_LO) && ({1'b0, line_base} < ROM_HI);
   assign cnt_nxt     = cnt_q + 1'b1;
   assign unused_bits = ^{rom_addr[WORD_ADR_SIZE+1:0], line_offset};

`ifdef ROM_FETCH_TIMEOUT_EN
   localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             fetch_err_q, fetch_err_d;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      wr_en      = 1'b0;
      wr_data    = mem_rdata;
      fill_nop   = 1'b0;
      advance    = 1'b0;
`ifdef ROM_FETCH_TIMEOUT_EN
      tmo_d       = tmo_q;
      fetch_err_d = fetch_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (rom_re) begin
               cnt_d = '0;
`ifdef ROM_FETCH_TIMEOUT_EN
               tmo_d = '0;
`endif
               if (in_range) begin
                  state_d    = S_FILL;
                  mem_req_d  = 1'b1;
                  mem_addr_d = line_idx;
               end else begin
                  fill_nop = 1'b1;
                  state_d  = S_DONE;
               end
            end
         end
         S_FILL: begin
            if (mem_req_q && mem_ack) begin
               wr_en   = 1'b1;
               advance = 1'b1;
`ifdef ROM_FETCH_TIMEOUT_EN
               tmo_d   = '0;
            end else if (!mem_req_q) begin
               // One idle request cycle after a watchdog expiry.
               mem_req_d = 1'b1;
            end else if (tmo_q == TMO_LIMIT) begin
               wr_en       = 1'b1;
               wr_data     = NOP_WORD;
               fetch_err_d = 1'b1;
               mem_req_d   = 1'b0;
               tmo_d       = '0;
               advance     = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
`endif
            end
            if (advance) begin
               if (cnt_q == LAST_CNT) begin
                  mem_req_d = 1'b0;
                  state_d   = S_DONE;
               end else begin
                  cnt_d      = cnt_nxt;
                  // Only the in-line word bits step; the line index is never carried into.
                  mem_addr_d = {mem_addr_q[MEM_AW-1:WORD_ADR_SIZE], cnt_nxt};
               end
            end
         end
         S_DONE:  state_d = S_COOL;
         S_COOL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rom_out_q[gi] <= '0;
            end else if (fill_nop) begin
               rom_out_q[gi] <= NOP_WORD;
            end else if (wr_en && (cnt_q == WORD_ADR_SIZE'(gi))) begin
               rom_out_q[gi] <= wr_data;
            end
         end
         assign rom_out[gi] = rom_out_q[gi];
      end
   endgenerate

`ifdef ROM_FETCH_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q       <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         tmo_q       <= tmo_d;
         fetch_err_q <= fetch_err_d;
      end
   end
   assign fetch_err = fetch_err_q;
`else
   assign fetch_err = 1'b0;
`endif

   assign rom_oe   = (state_q == S_DONE);
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_line_fetcher.sv
// Directed bench for rom_line_fetcher: idle/reset, zero-wait and wait-state fills,
// out-of-range NOP lines, back-to-back requests, async reset mid-fill, optional watchdog.
module tb_rom_line_fetcher;

   localparam int W   = 3;
   localparam int N   = 1 << W;
   localparam int AW  = 14;
   localparam int WIN = 64;

   logic              clk;
   logic              reset_n;
   logic              rom_re;
   logic [31:0]       rom_addr;
   logic [31:0]       rom_out [0:N-1];
   logic              rom_oe;
   logic              mem_req;
   logic [AW-1:0]     mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic              busy;
   logic              fetch_err;

   rom_line_fetcher #(
      .WORD_ADR_SIZE (W),
      .ROM_BASE      (32'h8000_0000),
      .ROM_WORDS     (16384),
      .MEM_AW        (AW),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rom_re   (rom_re),
      .rom_addr (rom_addr),
      .rom_out  (rom_out),
      .rom_oe   (rom_oe),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .fetch_err(fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   function automatic logic [31:0] rom_model(input int idx);
      return 32'hC0DE_0000 | 32'(idx);
   endfunction

   // Backing memory responder
   int          waits     = 0;
   int          wcnt      = 0;
   bit          stray     = 1'b0;
   bit          skip_en   = 1'b0;
   logic [AW-1:0] skip_addr = '0;

   always @(negedge clk) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if (stray) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hBAD0_BAD0;
      end else if (mem_req) begin
         if (skip_en && mem_addr == skip_addr) begin
            wcnt = 0;
         end else if (wcnt >= waits) begin
            mem_ack   = 1'b1;
            mem_rdata = rom_model(int'(mem_addr));
            wcnt      = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   // Per-cycle logs; index k is the cycle after request edge k-1.
   logic          req_log  [1:WIN];
   logic [AW-1:0] addr_log [1:WIN];
   logic          oe_log   [1:WIN];
   logic [31:0]   oe_line  [0:N-1];

   task automatic run_fetch(input logic [31:0] a, input int hold_cycles, input int win);
      @(negedge clk);
      rom_re   = 1'b1;
      rom_addr = a;
      @(posedge clk);
      for (int k = 1; k <= win; k++) begin
         @(negedge clk);
         if (k > hold_cycles) rom_re = 1'b0;
         if (hold_cycles == 0) rom_addr = 32'hDEAD_BEEF;
         req_log[k]  = mem_req;
         addr_log[k] = mem_addr;
         oe_log[k]   = rom_oe;
         if (rom_oe) for (int i = 0; i < N; i++) oe_line[i] = rom_out[i];
      end
      rom_re = 1'b0;
   endtask

   function automatic int first_oe(input int from, input int win);
      for (int k = from; k <= win; k++) if (oe_log[k]) return k;
      return -1;
   endfunction

   function automatic int oe_count(input int win);
      int c = 0;
      for (int k = 1; k <= win; k++) if (oe_log[k]) c++;
      return c;
   endfunction

   function automatic int req_count(input int win);
      int c = 0;
      for (int k = 1; k <= win; k++) if (req_log[k]) c++;
      return c;
   endfunction

   function automatic int first_req(input int from, input int win);
      for (int k = from; k <= win; k++) if (req_log[k]) return k;
      return -1;
   endfunction

   initial begin
      logic any_req, any_oe, any_busy;
      int   fo;

      reset_n  = 1'b0;
      rom_re   = 1'b0;
      rom_addr = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Idle for 10 cycles with stray acks that must be ignored
      any_req = 0; any_oe = 0; any_busy = 0;
      stray = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         any_req  |= mem_req;
         any_oe   |= rom_oe;
         any_busy |= busy;
      end
      stray = 1'b0;
      check_val("idle_mem_req", 32'(any_req), 32'd0);
      check_val("idle_rom_oe", 32'(any_oe), 32'd0);
      check_val("idle_busy", 32'(any_busy), 32'd0);
      check_val("idle_mem_addr", 32'(mem_addr), 32'd0);
      check_val("idle_fetch_err", 32'(fetch_err), 32'd0);
      for (int i = 0; i < N; i++) check_val($sformatf("idle_rom_out%0d", i), rom_out[i], 32'h0);

      // Zero-wait fill of line 0x8000_0020 (words 8..15)
      waits = 0;
      run_fetch(32'h8000_0024, 0, 14);
      for (int k = 1; k <= N; k++) check_val($sformatf("zw_addr_c%0d", k), 32'(addr_log[k]), 32'(7 + k));
      check_val("zw_req_cycles", 32'(req_count(14)), 32'd8);
      check_val("zw_oe_cycle", 32'(first_oe(1, 14)), 32'd9);
      check_val("zw_oe_count", 32'(oe_count(14)), 32'd1);
      for (int i = 0; i < N; i++) check_val($sformatf("zw_word%0d", i), oe_line[i], rom_model(8 + i));

      // Three wait states per word
      waits = 3;
      run_fetch(32'h8000_0024, 0, 40);
      check_val("ws_oe_cycle", 32'(first_oe(1, 40)), 32'd33);
      check_val("ws_oe_count", 32'(oe_count(40)), 32'd1);
      for (int i = 0; i < N; i++) check_val($sformatf("ws_word%0d", i), oe_line[i], rom_model(8 + i));
      waits = 0;

      // Out-of-range line
      run_fetch(32'h0000_0100, 0, 6);
      check_val("oor_req_cycles", 32'(req_count(6)), 32'd0);
      check_val("oor_oe_cycle", 32'(first_oe(1, 6)), 32'd1);
      check_val("oor_oe_count", 32'(oe_count(6)), 32'd1);
      for (int i = 0; i < N; i++) check_val($sformatf("oor_word%0d", i), oe_line[i], 32'h0000_0013);

      // Top of window is in range; first byte past it is not
      run_fetch(32'h8000_FFE4, 0, 14);
      check_val("top_addr_c1", 32'(addr_log[1]), 32'h3FF8);
      check_val("top_word7", oe_line[7], rom_model(16383));
      run_fetch(32'h8001_0000, 0, 6);
      check_val("past_req_cycles", 32'(req_count(6)), 32'd0);

      // rom_re held high: COOL masks it, next fetch issued from edge 11
      run_fetch(32'h8000_0040, 11, 30);
      check_val("b2b_oe1_cycle", 32'(first_oe(1, 30)), 32'd9);
      check_val("b2b_req2_cycle", 32'(first_req(10, 30)), 32'd12);
      check_val("b2b_oe2_cycle", 32'(first_oe(10, 30)), 32'd20);
      check_val("b2b_oe_count", 32'(oe_count(30)), 32'd2);

      // Asynchronous reset after the third ack
      @(negedge clk);
      rom_re   = 1'b1;
      rom_addr = 32'h8000_0024;
      @(posedge clk);
      @(negedge clk);
      rom_re = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_val("mid_req_before_rst", 32'(mem_req), 32'd1);
      reset_n = 1'b0;
      #1;
      check_val("mid_req_async", 32'(mem_req), 32'd0);
      check_val("mid_busy_async", 32'(busy), 32'd0);
      check_val("mid_addr_async", 32'(mem_addr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_fetch(32'h8000_0060, 0, 14);
      check_val("rst_refetch_addr_c1", 32'(addr_log[1]), 32'd24);
      check_val("rst_refetch_oe_cycle", 32'(first_oe(1, 14)), 32'd9);
      for (int i = 0; i < N; i++) check_val($sformatf("rst_word%0d", i), oe_line[i], rom_model(24 + i));

`ifdef ROM_FETCH_TIMEOUT_EN
      // Word 2 (address 10) never acknowledged; watchdog of 4 cycles
      skip_en   = 1'b1;
      skip_addr = AW'(10);
      run_fetch(32'h8000_0024, 0, 20);
      skip_en = 1'b0;
      check_val("tmo_gap_req_c7", 32'(req_log[7]), 32'd0);
      check_val("tmo_addr_c8", 32'(addr_log[8]), 32'd11);
      check_val("tmo_oe_cycle", 32'(first_oe(1, 20)), 32'd13);
      check_val("tmo_oe_count", 32'(oe_count(20)), 32'd1);
      check_val("tmo_fetch_err", 32'(fetch_err), 32'd1);
      for (int i = 0; i < N; i++)
         check_val($sformatf("tmo_word%0d", i), oe_line[i], (i == 2) ? 32'h0000_0013 : rom_model(8 + i));
`else
      check_val("no_tmo_fetch_err", 32'(fetch_err), 32'd0);
`endif

      fo = first_oe(1, 14);
      check_val("final_busy", 32'(busy), 32'd0);
      if (fo < 0) check_val("final_oe_seen", 32'(fo), 32'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
